// File: rtl/conv_stage_ctrl.sv
// Stage sequencer for one convolution pass: drives the 3-bit stage code shared by the
// weight and image caches, and reports row progress, result timing, completion and weight set.
module conv_stage_ctrl #(
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned IMAGE_SIZE     = 8,
    parameter int unsigned ARRAY_SIZE     = 6,
    parameter int unsigned WEIGHT_SET_NUM = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_hold,
    output logic [2:0] o_current_state,
    output logic [2:0] o_out_row,
    output logic [1:0] o_stage_cnt,
    output logic       o_result_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_weight_set
);

    localparam int unsigned OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [1:0]  CntLast  = 2'(KERNEL_SIZE - 1);
    localparam logic [2:0]  RowLast  = 3'(OUT_ROWS - 1);
    localparam logic        WsLast   = 1'(WEIGHT_SET_NUM - 1);

    if (ARRAY_SIZE != OUT_ROWS) begin : g_bad_array_size
        $error("ARRAY_SIZE must equal IMAGE_SIZE - KERNEL_SIZE + 1");
    end

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StPreload = 3'd1,
        StRow0    = 3'd2,
        StRow1    = 3'd3,
        StRow2    = 3'd4,
        StBias    = 3'd5,
        StLoad    = 3'd6,
        StIdle    = 3'd7
    } stage_e;

    stage_e     st_q, st_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] row_q, row_d;
    logic       ws_q, ws_d;
    logic       rv_q, rv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= StInit;
            cnt_q <= '0;
            row_q <= '0;
            ws_q  <= 1'b0;
            rv_q  <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
            ws_q  <= ws_d;
            rv_q  <= rv_d;
        end
    end

    // A hold freezes everything, including a pending result pulse, so that pulse
    // reappears once the hold drops instead of being lost.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        row_d = row_q;
        ws_d  = ws_q;
        rv_d  = rv_q;
        if (!i_hold) begin
            rv_d = (st_q == StBias);
            unique case (st_q)
                StInit: begin
                    if (i_start) begin
                        st_d = StPreload;
                    end
                end
                StPreload, StRow0, StRow1, StRow2: begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        unique case (st_q)
                            StPreload: st_d = StRow0;
                            StRow0:    st_d = StRow1;
                            StRow1:    st_d = StRow2;
                            default:   st_d = StBias;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                StBias: begin
                    st_d = (row_q == RowLast) ? StIdle : StLoad;
                end
                StLoad: begin
                    row_d = row_q + 3'd1;
                    st_d  = StRow0;
                end
                StIdle: begin
                    row_d = '0;
                    ws_d  = (ws_q == WsLast) ? 1'b0 : ws_q + 1'b1;
                    st_d  = StInit;
                end
                default: begin
                    st_d  = StInit;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Showing IDLE while held keeps the caches from advancing or clearing.
    always_comb begin
        o_current_state = i_hold ? 3'(StIdle) : 3'(st_q);
        o_out_row       = row_q;
        o_stage_cnt     = cnt_q;
        o_result_valid  = rv_q & ~i_hold;
        o_busy          = (st_q != StInit);
        o_done          = (st_q == StIdle) & ~i_hold;
        o_weight_set    = ws_q;
    end

endmodule

// File: tb/tb_conv_stage_ctrl.sv
// Directed bench for conv_stage_ctrl: nominal pass timing, hold behaviour, back-to-back
// passes and mid-pass reset, all against hand-derived cycle tables.
module tb_conv_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_hold;
    logic [2:0] o_current_state;
    logic [2:0] o_out_row;
    logic [1:0] o_stage_cnt;
    logic       o_result_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_weight_set;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    conv_stage_ctrl #(
        .KERNEL_SIZE   (3),
        .IMAGE_SIZE    (8),
        .ARRAY_SIZE    (6),
        .WEIGHT_SET_NUM(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_hold         (i_hold),
        .o_current_state(o_current_state),
        .o_out_row      (o_out_row),
        .o_stage_cnt    (o_stage_cnt),
        .o_result_valid (o_result_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_weight_set   (o_weight_set)
    );

    always #5 clk = ~clk;

    // Cycle c counts edges after the edge E0 that sampled i_start.
    function automatic int exp_state(int c);
        int k;
        if (c >= 1 && c <= 3) return 1;
        if (c >= 4 && c <= 68) begin
            k = (c - 4) % 11;
            if (k < 3) return 2;
            if (k < 6) return 3;
            if (k < 9) return 4;
            if (k == 9) return 5;
            return 6;
        end
        if (c == 69) return 7;
        return 0;
    endfunction

    function automatic int exp_cnt(int c);
        int k;
        if (c >= 1 && c <= 3) return c - 1;
        if (c >= 4 && c <= 68) begin
            k = (c - 4) % 11;
            if (k < 9) return k % 3;
        end
        return 0;
    endfunction

    function automatic int exp_row(int c);
        if (c >= 4 && c <= 69) return (c - 4) / 11;
        return 0;
    endfunction

    function automatic int exp_rv(int c);
        return (c >= 14 && c <= 69 && (c - 14) % 11 == 0) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_pass();
        i_start = 1'b1;
        cyc     = 0;
        step();
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_start = 1'b0;
        i_hold  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (o_current_state !== 3'd0 || o_out_row !== 3'd0 || o_stage_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_regs got state=%0d row=%0d cnt=%0d exp 0/0/0",
                     o_current_state, o_out_row, o_stage_cnt);
        end
        n_cmp++;
        if ({o_result_valid, o_busy, o_done, o_weight_set} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got rv/busy/done/ws=%b exp 0000",
                     {o_result_valid, o_busy, o_done, o_weight_set});
        end
        // Start is ignored while held in INIT.
        i_hold  = 1'b1;
        i_start = 1'b1;
        #1;
        n_cmp++;
        if (o_current_state !== 3'd7) begin
            n_bad++;
            $display("FAIL hold_code got=%0d exp=7", o_current_state);
        end
        step();
        step();
        i_start = 1'b0;
        i_hold  = 1'b0;
        #1;
        n_cmp++;
        if (o_current_state !== 3'd0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_start_ignored got state=%0d busy=%b exp 0/0",
                     o_current_state, o_busy);
        end
        step();
    endtask

    task automatic test_nominal();
        start_pass();
        for (int c = 1; c <= 70; c++) begin
            n_cmp++;
            if (o_current_state !== 3'(exp_state(c)) || o_stage_cnt !== 2'(exp_cnt(c)) ||
                o_out_row !== 3'(exp_row(c))) begin
                n_bad++;
                $display("FAIL nominal_seq cyc=%0d got st/cnt/row=%0d/%0d/%0d exp %0d/%0d/%0d",
                         c, o_current_state, o_stage_cnt, o_out_row,
                         exp_state(c), exp_cnt(c), exp_row(c));
            end
            n_cmp++;
            if (o_result_valid !== 1'(exp_rv(c)) || o_done !== (c == 69) ||
                o_busy !== (c != 70) || o_weight_set !== (c == 70)) begin
                n_bad++;
                $display("FAIL nominal_flags cyc=%0d got rv/done/busy/ws=%b%b%b%b exp %b%b%b%b",
                         c, o_result_valid, o_done, o_busy, o_weight_set,
                         1'(exp_rv(c)), c == 69, c != 70, c == 70);
            end
            if (c < 70) step();
        end
    endtask

    task automatic test_hold_row1();
        int pulses = 0;
        int done_at = -1;
        do_reset();
        start_pass();
        while (cyc < 8) step();
        n_cmp++;
        if (o_current_state !== 3'd3 || o_stage_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL hold_pre got st/cnt=%0d/%0d exp 3/1", o_current_state, o_stage_cnt);
        end
        i_hold = 1'b1;
        #1;
        for (int h = 0; h < 4; h++) begin
            n_cmp++;
            if (o_current_state !== 3'd7 || o_stage_cnt !== 2'd1 || o_done !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_frozen cyc=%0d got st/cnt/done=%0d/%0d/%b exp 7/1/0",
                         cyc, o_current_state, o_stage_cnt, o_done);
            end
            step();
        end
        i_hold = 1'b0;
        #1;
        n_cmp++;
        if (o_current_state !== 3'd3 || o_stage_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL hold_resume got st/cnt=%0d/%0d exp 3/1", o_current_state, o_stage_cnt);
        end
        while (done_at < 0 && cyc < 120) begin
            if (o_result_valid) pulses++;
            if (o_done) done_at = cyc;
            else step();
        end
        n_cmp++;
        if (done_at != 73) begin
            n_bad++;
            $display("FAIL hold_done_cycle got=%0d exp=73", done_at);
        end
        n_cmp++;
        if (pulses != 6) begin
            n_bad++;
            $display("FAIL hold_rv_count got=%0d exp=6", pulses);
        end
        step();
    endtask

    task automatic test_hold_bias();
        int pulses = 0;
        int dones = 0;
        do_reset();
        start_pass();
        while (cyc < 68) begin
            if (o_result_valid) pulses++;
            step();
        end
        n_cmp++;
        if (o_current_state !== 3'd5) begin
            n_bad++;
            $display("FAIL bias_pre got=%0d exp=5", o_current_state);
        end
        i_hold = 1'b1;
        while (cyc < 71) begin
            #1;
            n_cmp++;
            if (o_result_valid !== 1'b0 || o_done !== 1'b0 || o_current_state !== 3'd7) begin
                n_bad++;
                $display("FAIL bias_held cyc=%0d got rv/done/st=%b/%b/%0d exp 0/0/7",
                         cyc, o_result_valid, o_done, o_current_state);
            end
            step();
        end
        i_hold = 1'b0;
        #1;
        n_cmp++;
        if (o_current_state !== 3'd5 || o_result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bias_release got st/rv=%0d/%b exp 5/0", o_current_state, o_result_valid);
        end
        while (cyc < 75) begin
            if (o_result_valid) pulses++;
            if (o_done) dones++;
            if (cyc == 72) begin
                n_cmp++;
                if (o_result_valid !== 1'b1 || o_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bias_slip cyc=72 got rv/done=%b/%b exp 1/1",
                             o_result_valid, o_done);
                end
            end
            step();
        end
        n_cmp++;
        if (pulses != 6 || dones != 1) begin
            n_bad++;
            $display("FAIL bias_counts got rv=%0d done=%0d exp 6/1", pulses, dones);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_start = 1'b1;
        cyc     = 0;
        step();
        for (int c = 1; c <= 210; c++) begin
            n_cmp++;
            if (o_done !== (c % 70 == 69) || (o_current_state == 3'd0) !== (c % 70 == 0)) begin
                n_bad++;
                $display("FAIL b2b_seq cyc=%0d got st=%0d done=%b", c, o_current_state, o_done);
            end
            if (c % 70 == 0) begin
                n_cmp++;
                if (o_weight_set !== ((c / 70) % 2 == 1)) begin
                    n_bad++;
                    $display("FAIL b2b_ws cyc=%0d got=%b exp=%b", c, o_weight_set,
                             (c / 70) % 2 == 1);
                end
            end
            if (c == 71 || c == 141) begin
                n_cmp++;
                if (o_current_state !== 3'd1) begin
                    n_bad++;
                    $display("FAIL b2b_restart cyc=%0d got=%0d exp=1", c, o_current_state);
                end
            end
            step();
        end
        // Edge 211 started a fourth pass on weight set 1; count relative to it.
        i_start = 1'b0;
        cyc     = 1;
    endtask

    task automatic test_reset_mid_pass();
        while (cyc < 47) step();
        n_cmp++;
        if (o_current_state !== 3'd6 || o_out_row !== 3'd3 || o_weight_set !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre got st/row/ws=%0d/%0d/%b exp 6/3/1",
                     o_current_state, o_out_row, o_weight_set);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_current_state !== 3'd0 || o_out_row !== 3'd0 || o_weight_set !== 1'b0 ||
            o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got st/row/ws/busy=%0d/%0d/%b/%b exp 0/0/0/0",
                     o_current_state, o_out_row, o_weight_set, o_busy);
        end
        step();
        n_cmp++;
        if (o_result_valid !== 1'b0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_pulse got rv/done=%b/%b exp 0/0", o_result_valid, o_done);
        end
        rst = 1'b0;
        step();
        start_pass();
        while (cyc < 69) step();
        n_cmp++;
        if (o_done !== 1'b1 || o_out_row !== 3'd5 || o_weight_set !== 1'b0) begin
            n_bad++;
            $display("FAIL fresh_pass got done/row/ws=%b/%0d/%b exp 1/5/0",
                     o_done, o_out_row, o_weight_set);
        end
        step();
        n_cmp++;
        if (o_current_state !== 3'd0 || o_out_row !== 3'd0 || o_weight_set !== 1'b1) begin
            n_bad++;
            $display("FAIL fresh_end got st/row/ws=%0d/%0d/%b exp 0/0/1",
                     o_current_state, o_out_row, o_weight_set);
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_hold  = 1'b0;
        test_reset();
        test_nominal();
        test_hold_row1();
        test_hold_bias();
        test_back_to_back();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
